fifo_burst_scheduler: RTL

Read-side controller for the width-converting block-RAM FIFO in the load/store path. It watches the FIFO read-domain occupancy and decides when to drain. Each drain is one burst: a length request is sent to the downstream requester, then exactly that many words stream out under a valid/ready handshake with `last` marking the final beat. The block hides the FIFO's 1-cycle standard-mode read latency behind a 2-entry skid buffer, and provides timeout and flush so partial bursts do not stall.

---
 rtl/fifo_burst_scheduler_pkg.sv | 13 +
 rtl/fifo_skid_buffer.sv | 55 +++++
 rtl/fifo_burst_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_burst_scheduler_pkg.sv
// Shared load/store definitions for the FIFO read-side burst scheduler.
package fifo_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

  localparam int SKID_DEPTH     = 2;
  localparam int SKID_OCC_WIDTH = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry fall-through skid buffer that absorbs FIFO read data while the
// downstream consumer stalls; an empty buffer passes incoming data straight out.
module fifo_skid_buffer
  import fifo_burst_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SKID_OCC_WIDTH-1:0] occupancy
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;
  logic             store;
  logic             consume;

  // Head selection and push/pop decisions, bypassing storage when empty.
  always_comb begin
    out_valid = (occupancy != '0) || in_valid;
    out_data  = (occupancy != '0) ? mem[rd_ptr] : in_data;
    pop       = out_valid && out_ready;
    store     = in_valid && !((occupancy == '0) && pop);
    consume   = pop && (occupancy != '0);
  end

  // Storage, pointers and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (consume) rd_ptr <= ~rd_ptr;
      case ({store, consume})
        2'b10:   occupancy <= occupancy + SKID_OCC_WIDTH'(1);
        2'b01:   occupancy <= occupancy - SKID_OCC_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// Read-side burst scheduler: decides when to drain the FIFO, issues a length
// request, then streams exactly that many words through a skid buffer.
module fifo_burst_scheduler
  import fifo_burst_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6,
  parameter int MAX_BURST   = 16,
  parameter int LEN_WIDTH   = $clog2(MAX_BURST) + 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_rd_data_count,
  input  logic                   fifo_rd_rst_busy,
  output logic                   fifo_rd_en,
  output logic                   req_valid,
  output logic [LEN_WIDTH-1:0]   req_len,
  input  logic                   req_ready,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   flush_done
);

  localparam int TIMER_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  sched_state_t               state;
  sched_state_t               state_next;
  logic [LEN_WIDTH-1:0]       len;
  logic [LEN_WIDTH-1:0]       issued;
  logic [LEN_WIDTH-1:0]       sent;
  logic [LEN_WIDTH-1:0]       trigger_len;
  logic [TIMER_WIDTH-1:0]     idle_timer;
  logic                       flush_pending;
  logic                       in_flight;
  logic [SKID_OCC_WIDTH-1:0]  skid_occupancy;
  logic [SKID_OCC_WIDTH:0]    outstanding;
  logic                       skid_valid;
  logic [DATA_WIDTH-1:0]      skid_data;
  logic                       has_data;
  logic                       full_burst;
  logic                       timed_out;
  logic                       trigger;
  logic                       skid_empty;
  logic                       beat_fire;
  logic                       last_fire;

  fifo_skid_buffer #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_flight),
    .in_data   (fifo_dout),
    .out_ready (m_ready),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .occupancy (skid_occupancy)
  );

  // Burst trigger, flush completion and output-beat qualification.
  always_comb begin
    has_data    = fifo_rd_data_count != '0;
    full_burst  = int'(fifo_rd_data_count) >= MAX_BURST;
    timed_out   = (TIMEOUT != 0) && (int'(idle_timer) >= TIMEOUT);
    trigger     = (state == IDLE) && !fifo_rd_rst_busy && has_data &&
                  (enable || flush_pending) &&
                  (full_burst || timed_out || flush_pending);
    trigger_len = full_burst ? LEN_WIDTH'(MAX_BURST) : LEN_WIDTH'(fifo_rd_data_count);
    outstanding = {1'b0, skid_occupancy} + {{SKID_OCC_WIDTH{1'b0}}, in_flight};
    skid_empty  = (skid_occupancy == '0) && !in_flight;
    flush_done  = flush_pending && (state == IDLE) && !has_data && skid_empty;
    busy        = (state != IDLE) || !skid_empty;
    m_valid     = skid_valid;
    m_data      = skid_valid ? skid_data : '0;
    m_last      = skid_valid && (state == STREAM) && (sent == len - LEN_WIDTH'(1));
    beat_fire   = m_valid && m_ready;
    last_fire   = beat_fire && m_last;
    req_len     = len;
  end

  // Next-state logic plus request and FIFO read strobes.
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_next = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_next = STREAM;
      end
      STREAM: begin
        fifo_rd_en = !fifo_rd_rst_busy && (issued < len) && !fifo_empty &&
                     (int'(outstanding) < SKID_DEPTH);
        if (last_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Burst length latch and per-burst read/beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      issued    <= '0;
      sent      <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= fifo_rd_en;
      if (trigger) begin
        len    <= trigger_len;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + LEN_WIDTH'(1);
        if (beat_fire)  sent   <= sent + LEN_WIDTH'(1);
      end
    end
  end

  // Idle timer that forces a short burst when a partial fill lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_timer <= '0;
    end else if (state == IDLE) begin
      if (trigger || !has_data) idle_timer <= '0;
      else if (!full_burst && int'(idle_timer) < TIMEOUT) idle_timer <= idle_timer + TIMER_WIDTH'(1);
    end
  end

  // Flush request latch, released when the drain completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          flush_pending <= 1'b0;
    else if (flush_done) flush_pending <= 1'b0;
    else if (flush)      flush_pending <= 1'b1;
  end

endmodule
